// File: rtl/custom_alu_issue.sv
// Issue/response front end for the custom-0 ALU: decodes requests into a registered
// issue stage that drives the ALU, and queues results in a 2-entry in-order response buffer.
module custom_alu_issue #(
   parameter int unsigned RSP_DEPTH = 2,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_funct3,
   input  logic [6:0]       req_funct7,
   input  logic [31:0]      req_rs1,
   input  logic [31:0]      req_rs2,
   input  logic [4:0]       req_rd,
   output logic [31:0]      alu_operand_a,
   output logic [31:0]      alu_operand_b,
   output logic [3:0]       alu_op_code,
   input  logic [31:0]      alu_result,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_data,
   output logic [4:0]       rsp_rd,
   output logic             rsp_illegal,
   output logic [CNT_W-1:0] issued_count,
   output logic [CNT_W-1:0] illegal_count
);
   localparam int unsigned DATA_W = 32;
   localparam int unsigned RD_W   = 5;
   localparam int unsigned OP_W   = 4;
   localparam int unsigned CNT_PW = 2;
   localparam logic [OP_W-1:0] OP_ILLEGAL = 4'b1111;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [RD_W-1:0]   rd;
      logic              illegal;
   } rsp_entry_t;

   logic              s1_valid_q, s1_valid_d;
   logic [DATA_W-1:0] s1_a_q, s1_a_d;
   logic [DATA_W-1:0] s1_b_q, s1_b_d;
   logic [OP_W-1:0]   s1_op_q, s1_op_d;
   logic [RD_W-1:0]   s1_rd_q, s1_rd_d;
   logic              s1_ill_q, s1_ill_d;
   rsp_entry_t        buf_q [RSP_DEPTH];
   rsp_entry_t        buf_d [RSP_DEPTH];
   logic              head_q, head_d;
   logic [CNT_PW-1:0] count_q, count_d;
   logic [CNT_W-1:0]  issued_q, issued_d;
   logic [CNT_W-1:0]  illegal_q, illegal_d;

   logic              req_illegal_c;
   logic [OP_W-1:0]   req_op_c;
   logic              pop_c;
   logic              s1_move_c;
   logic              accept_c;
   logic              tail_c;

   // Decode: only funct7 == 0 with funct3 0..5 is a real ALU op
   always_comb begin
      req_illegal_c = (req_funct7 != 7'd0) || (req_funct3 > 3'd5);
      req_op_c      = req_illegal_c ? OP_ILLEGAL : {1'b0, req_funct3};
   end

   // Handshake: S1 may advance into a free slot or into the slot freed by a same-edge pop
   always_comb begin
      rsp_valid = (count_q != '0);
      pop_c     = rsp_valid && rsp_ready;
      s1_move_c = s1_valid_q && ((count_q < CNT_PW'(RSP_DEPTH)) || pop_c);
      req_ready = !s1_valid_q || s1_move_c;
      accept_c  = req_valid && req_ready;
      tail_c    = head_q + count_q[0];
   end

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_op_d    = s1_op_q;
      s1_rd_d    = s1_rd_q;
      s1_ill_d   = s1_ill_q;
      buf_d      = buf_q;
      head_d     = head_q;
      count_d    = count_q;
      issued_d   = issued_q;
      illegal_d  = illegal_q;

      if (accept_c) begin
         s1_valid_d = 1'b1;
         s1_a_d     = req_rs1;
         s1_b_d     = req_rs2;
         s1_op_d    = req_op_c;
         s1_rd_d    = req_rd;
         s1_ill_d   = req_illegal_c;
      end else if (s1_move_c) begin
         s1_valid_d = 1'b0;
      end

      // At count 2 with a pop the tail equals the head, which is being vacated
      if (s1_move_c) begin
         buf_d[tail_c].data    = s1_ill_q ? '0 : alu_result;
         buf_d[tail_c].rd      = s1_rd_q;
         buf_d[tail_c].illegal = s1_ill_q;
      end
      if (pop_c) begin
         head_d = head_q + 1'b1;
      end
      count_d = count_q + CNT_PW'(s1_move_c) - CNT_PW'(pop_c);

      if (accept_c && (issued_q != '1)) begin
         issued_d = issued_q + CNT_W'(1);
      end
      if (accept_c && req_illegal_c && (illegal_q != '1)) begin
         illegal_d = illegal_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_op_q    <= '0;
         s1_rd_q    <= '0;
         s1_ill_q   <= 1'b0;
         for (int i = 0; i < RSP_DEPTH; i++) begin
            buf_q[i] <= '0;
         end
         head_q     <= 1'b0;
         count_q    <= '0;
         issued_q   <= '0;
         illegal_q  <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s1_op_q    <= s1_op_d;
         s1_rd_q    <= s1_rd_d;
         s1_ill_q   <= s1_ill_d;
         buf_q      <= buf_d;
         head_q     <= head_d;
         count_q    <= count_d;
         issued_q   <= issued_d;
         illegal_q  <= illegal_d;
      end
   end

   assign alu_operand_a = s1_a_q;
   assign alu_operand_b = s1_b_q;
   assign alu_op_code   = s1_op_q;
   assign rsp_data      = buf_q[head_q].data;
   assign rsp_rd        = buf_q[head_q].rd;
   assign rsp_illegal   = buf_q[head_q].illegal;
   assign issued_count  = issued_q;
   assign illegal_count = illegal_q;

endmodule

// File: tb/tb_custom_alu_issue.sv
// Bench for custom_alu_issue: transaction-level reference model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_custom_alu_issue;
   typedef struct {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        ill;
   } rsp_t;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_funct3;
   logic [6:0]  req_funct7;
   logic [31:0] req_rs1;
   logic [31:0] req_rs2;
   logic [4:0]  req_rd;
   logic [31:0] alu_operand_a;
   logic [31:0] alu_operand_b;
   logic [3:0]  alu_op_code;
   logic [31:0] alu_result;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic [4:0]  rsp_rd;
   logic        rsp_illegal;
   logic [15:0] issued_count;
   logic [15:0] illegal_count;

   // Narrow-counter instance sharing the same stimulus, to reach saturation quickly
   logic        sat_req_ready;
   logic [31:0] sat_alu_a;
   logic [31:0] sat_alu_b;
   logic [3:0]  sat_alu_op;
   logic [31:0] sat_alu_result;
   logic        sat_rsp_valid;
   logic [31:0] sat_rsp_data;
   logic [4:0]  sat_rsp_rd;
   logic        sat_rsp_illegal;
   logic [1:0]  sat_issued;
   logic [1:0]  sat_illegal;

   int errors = 0;
   int checks = 0;

   rsp_t        m_rsp[$];
   rsp_t        m_s1;
   bit          m_s1_v;
   logic [31:0] m_alu_a, m_alu_b;
   logic [3:0]  m_alu_op;
   int          m_issued, m_illegal;
   rsp_t        got[$];

   custom_alu_issue #(.RSP_DEPTH(2), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_funct3(req_funct3), .req_funct7(req_funct7),
      .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
      .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
      .alu_op_code(alu_op_code), .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_rd(rsp_rd), .rsp_illegal(rsp_illegal),
      .issued_count(issued_count), .illegal_count(illegal_count)
   );

   custom_alu_issue #(.RSP_DEPTH(2), .CNT_W(2)) u_sat (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(sat_req_ready),
      .req_funct3(req_funct3), .req_funct7(req_funct7),
      .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
      .alu_operand_a(sat_alu_a), .alu_operand_b(sat_alu_b),
      .alu_op_code(sat_alu_op), .alu_result(sat_alu_result),
      .rsp_valid(sat_rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(sat_rsp_data), .rsp_rd(sat_rsp_rd), .rsp_illegal(sat_rsp_illegal),
      .issued_count(sat_issued), .illegal_count(sat_illegal)
   );

   function automatic logic [31:0] clz32(input logic [31:0] x);
      int n = 0;
      while (n < 32 && x[31 - n] == 1'b0) n++;
      return 32'(n);
   endfunction

   // External combinational ALU; illegal op code returns junk that must never reach rsp_data
   function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      case (op)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return a & b;
         4'd3: return a | b;
         4'd4: return 32'($countones(a));
         4'd5: return clz32(a);
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   function automatic rsp_t ref_rsp(input logic [2:0] f3, input logic [6:0] f7,
                                    input logic [31:0] a, input logic [31:0] b,
                                    input logic [4:0] rd);
      rsp_t r;
      r.rd  = rd;
      r.ill = (f7 != 7'd0) || (f3 >= 3'd6);
      if (r.ill) r.data = 32'd0;
      else begin
         case (f3)
            3'd0: r.data = a + b;
            3'd1: r.data = a - b;
            3'd2: r.data = a & b;
            3'd3: r.data = a | b;
            3'd4: r.data = 32'($countones(a));
            default: r.data = clz32(a);
         endcase
      end
      return r;
   endfunction

   assign alu_result     = alu_model(alu_op_code, alu_operand_a, alu_operand_b);
   assign sat_alu_result = alu_model(sat_alu_op, sat_alu_a, sat_alu_b);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Per-cycle compare against the model, then advance the model across the coming edge
   always @(negedge clk) begin
      int  sz;
      bit  exp_ready, pop, move;
      int  sat_iss, sat_ill;
      if (!rst_n) begin
         m_rsp.delete();
         m_s1_v = 0; m_alu_a = '0; m_alu_b = '0; m_alu_op = '0;
         m_issued = 0; m_illegal = 0;
         chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
         chk("rst_rsp_data", rsp_data, 32'd0);
         chk("rst_rsp_rd", 32'(rsp_rd), 32'd0);
         chk("rst_rsp_illegal", 32'(rsp_illegal), 32'd0);
         chk("rst_req_ready", 32'(req_ready), 32'd1);
         chk("rst_alu_a", alu_operand_a, 32'd0);
         chk("rst_alu_b", alu_operand_b, 32'd0);
         chk("rst_alu_op", 32'(alu_op_code), 32'd0);
         chk("rst_issued", 32'(issued_count), 32'd0);
         chk("rst_illegal", 32'(illegal_count), 32'd0);
      end else begin
         sz        = m_rsp.size();
         exp_ready = !m_s1_v || sz < 2 || (sz > 0 && rsp_ready);
         chk("req_ready", 32'(req_ready), 32'(exp_ready));
         chk("rsp_valid", 32'(rsp_valid), 32'(sz > 0));
         if (sz > 0) begin
            chk("rsp_data", rsp_data, m_rsp[0].data);
            chk("rsp_rd", 32'(rsp_rd), 32'(m_rsp[0].rd));
            chk("rsp_illegal", 32'(rsp_illegal), 32'(m_rsp[0].ill));
            chk("sat_rsp_data", sat_rsp_data, m_rsp[0].data);
            chk("sat_rsp_tag", {26'd0, sat_rsp_rd, sat_rsp_illegal},
                {26'd0, m_rsp[0].rd, m_rsp[0].ill});
         end
         chk("alu_a", alu_operand_a, m_alu_a);
         chk("alu_b", alu_operand_b, m_alu_b);
         chk("alu_op", 32'(alu_op_code), 32'(m_alu_op));
         chk("issued_count", 32'(issued_count), 32'(m_issued));
         chk("illegal_count", 32'(illegal_count), 32'(m_illegal));
         sat_iss = (m_issued > 3) ? 3 : m_issued;
         sat_ill = (m_illegal > 3) ? 3 : m_illegal;
         chk("sat_req_ready", 32'(sat_req_ready), 32'(exp_ready));
         chk("sat_rsp_valid", 32'(sat_rsp_valid), 32'(sz > 0));
         chk("sat_issued", 32'(sat_issued), 32'(sat_iss));
         chk("sat_illegal", 32'(sat_illegal), 32'(sat_ill));

         if (rsp_valid && rsp_ready) got.push_back('{rsp_data, rsp_rd, rsp_illegal});
         pop  = sz > 0 && rsp_ready;
         move = m_s1_v && (sz < 2 || pop);
         if (pop) void'(m_rsp.pop_front());
         if (move) begin
            m_rsp.push_back(m_s1);
            m_s1_v = 0;
         end
         if (req_valid && exp_ready) begin
            m_s1     = ref_rsp(req_funct3, req_funct7, req_rs1, req_rs2, req_rd);
            m_s1_v   = 1;
            m_alu_a  = req_rs1;
            m_alu_b  = req_rs2;
            m_alu_op = m_s1.ill ? 4'hF : {1'b0, req_funct3};
            if (m_issued < 16'hFFFF) m_issued++;
            if (m_s1.ill && m_illegal < 16'hFFFF) m_illegal++;
         end
      end
   end

   // Present one request and hold it until accepted; returns 1 time unit after the accepting edge
   task automatic send(input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd);
      bit acc = 0;
      int n = 0;
      req_valid = 1'b1; req_funct3 = f3; req_funct7 = f7;
      req_rs1 = a; req_rs2 = b; req_rd = rd;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = req_ready;
         @(posedge clk); #1;
         n++;
      end
      if (!acc) begin
         checks++; errors++;
         $display("FAIL send_timeout: got req_ready 0 expected accept within 50 cycles (rd %0d)", rd);
      end
      req_valid = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk_got(input string name, input int idx, input logic [31:0] data,
                          input logic [4:0] rd, input logic ill);
      if (idx < got.size()) begin
         chk({name, "_data"}, got[idx].data, data);
         chk({name, "_tag"}, {26'd0, got[idx].rd, got[idx].ill}, {26'd0, rd, ill});
      end else begin
         checks++; errors++;
         $display("FAIL %s_missing: got %0d responses expected entry %0d", name, got.size(), idx);
      end
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
      req_funct3 = '0; req_funct7 = '0; req_rs1 = '0; req_rs2 = '0; req_rd = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset mid-stream with two responses buffered
      send(3'd0, 7'd0, 32'd1, 32'd2, 5'd1);
      send(3'd1, 7'd0, 32'd9, 32'd4, 5'd2);
      cycles(1);
      chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
      chk("pre_rst_issued", 32'(issued_count), 32'd2);
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(rsp_valid), 32'd0);
      chk("async_rst_ready", 32'(req_ready), 32'd1);
      chk("async_rst_issued", 32'(issued_count), 32'd0);
      chk("async_rst_data", rsp_data, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      cycles(1);

      // Single ADD
      send(3'd0, 7'd0, 32'h0000_0005, 32'h0000_0003, 5'd7);
      chk("add_issue_op", 32'(alu_op_code), 32'd0);
      chk("add_issue_a", alu_operand_a, 32'd5);
      cycles(1);
      chk("add_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("add_rsp_data", rsp_data, 32'd8);
      chk("add_rsp_rd", 32'(rsp_rd), 32'd7);
      chk("add_rsp_illegal", 32'(rsp_illegal), 32'd0);
      cycles(2);
      chk("add_stable_data", rsp_data, 32'd8);
      rsp_ready = 1'b1;
      cycles(1);

      // Back-to-back stream at full rate
      got.delete();
      send(3'd1, 7'd0, 32'd10, 32'd4, 5'd1);
      send(3'd2, 7'd0, 32'h0000_F0F0, 32'h0000_FF00, 5'd2);
      send(3'd3, 7'd0, 32'h1, 32'h2, 5'd3);
      send(3'd4, 7'd0, 32'hFF, 32'h0, 5'd4);
      cycles(4);
      chk_got("stream0", 0, 32'd6, 5'd1, 1'b0);
      chk_got("stream1", 1, 32'h0000_F000, 5'd2, 1'b0);
      chk_got("stream2", 2, 32'h3, 5'd3, 1'b0);
      chk_got("stream3", 3, 32'd8, 5'd4, 1'b0);
      chk("stream_issued", 32'(issued_count), 32'd5);

      // Backpressure: three fit, the fourth waits for the first pop
      rsp_ready = 1'b0;
      got.delete();
      send(3'd0, 7'd0, 32'd1, 32'd1, 5'd8);
      send(3'd1, 7'd0, 32'd0, 32'd1, 5'd9);
      send(3'd5, 7'd0, 32'h0001_0000, 32'd0, 5'd10);
      req_valid = 1'b1; req_funct3 = 3'd4; req_funct7 = 7'd0;
      req_rs1 = 32'hFFFF_FFFF; req_rs2 = 32'd0; req_rd = 5'd11;
      repeat (3) begin
         @(negedge clk);
         chk("bp_blocked", 32'(req_ready), 32'd0);
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_accept_on_pop", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      cycles(5);
      chk_got("bp0", 0, 32'd2, 5'd8, 1'b0);
      chk_got("bp1", 1, 32'hFFFF_FFFF, 5'd9, 1'b0);
      chk_got("bp2", 2, 32'd15, 5'd10, 1'b0);
      chk_got("bp3", 3, 32'd32, 5'd11, 1'b0);

      // Illegal encodings
      got.delete();
      send(3'd0, 7'h20, 32'd1, 32'd2, 5'd3);
      chk("ill_issue_op", 32'(alu_op_code), 32'hF);
      cycles(3);
      send(3'd6, 7'd0, 32'd1, 32'd2, 5'd4);
      cycles(3);
      chk_got("ill0", 0, 32'd0, 5'd3, 1'b1);
      chk_got("ill1", 1, 32'd0, 5'd4, 1'b1);
      chk("ill_count", 32'(illegal_count), 32'd2);

      // Saturation on the narrow-counter instance
      chk("sat_issued_pinned", 32'(sat_issued), 32'd3);
      chk("sat_illegal_pre", 32'(sat_illegal), 32'd2);
      send(3'd7, 7'd0, 32'd0, 32'd0, 5'd5);
      send(3'd7, 7'd1, 32'd0, 32'd0, 5'd6);
      send(3'd2, 7'h7F, 32'd0, 32'd0, 5'd7);
      cycles(3);
      chk("sat_illegal_pinned", 32'(sat_illegal), 32'd3);
      chk("wide_illegal", 32'(illegal_count), 32'd5);
      chk("wide_issued", 32'(issued_count), 32'd14);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
